// File: rtl/alu_op_sequencer.sv
// Program-driven sequencer for the shared 8-bit ALU: fetches opcodes, streams operand pairs,
// returns results. Optional macro SEQ_DIVZ_HALT_EN aborts the program on a divide-by-zero result.
module alu_op_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int ALU_LAT    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [3:0] prog_data,
  input  logic [4:0] prog_len,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic [3:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_load,
  output logic [2:0] alu_attr,
  input  logic [7:0] alu_out,
  input  logic [8:0] alu_flag,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_out,
  output logic [8:0] res_flag,
  output logic [3:0] res_op,
`ifdef SEQ_DIVZ_HALT_EN
  output logic       err,
`endif
  output logic [2:0] state_dbg
);

  // Handshakes: a transfer occurs on a rising edge where valid and ready are both high.
  // in_ready is a pure function of state; res_valid stays high until its transfer edge.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_COLLECT = 3'd2,
    S_EXEC    = 3'd3,
    S_OUTPUT  = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] mem [PROG_DEPTH];
  logic [3:0] pc;
  logic [4:0] len_q, len_eff;
  logic [2:0] pair_cnt, lat_cnt, npair;
  logic       in_fire, res_fire, last_pair, lat_hit, last_instr, abort_run;

  assign len_eff    = (prog_len > 5'd16) ? 5'd16 : prog_len;
  assign busy       = (state != S_IDLE);
  assign in_ready   = (state == S_COLLECT);
  assign state_dbg  = state;
  assign in_fire    = in_ready & in_valid;
  assign res_fire   = (state == S_OUTPUT) & res_ready;
  assign last_pair  = (pair_cnt == npair - 3'd1);
  assign lat_hit    = (lat_cnt == 3'(ALU_LAT));
  assign last_instr = (({1'b0, pc} + 5'd1) == len_q);

`ifdef SEQ_DIVZ_HALT_EN
  assign abort_run = (res_op == 4'd3) && res_flag[0];
`else
  assign abort_run = 1'b0;
`endif

  // Tournament opcodes take several attribute pairs before the ALU result is meaningful.
  always_comb begin
    npair = 3'd1;
    if (alu_op == 4'd13 || alu_op == 4'd14) npair = 3'd2;
    else if (alu_op == 4'd15)               npair = 3'd5;
  end

  always_ff @(posedge clk) begin
    if (reset && state == S_IDLE && prog_we) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start && len_eff != 5'd0) state_nxt = S_FETCH;
      S_FETCH:   state_nxt = S_COLLECT;
      S_COLLECT: if (in_fire && last_pair) state_nxt = S_EXEC;
      S_EXEC:    if (lat_hit) state_nxt = S_OUTPUT;
      S_OUTPUT:  if (res_fire) state_nxt = (abort_run || last_instr) ? S_IDLE : S_FETCH;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc        <= '0;
      len_q     <= '0;
      pair_cnt  <= '0;
      lat_cnt   <= '0;
      done      <= 1'b0;
      alu_load  <= 1'b0;
      res_valid <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_attr  <= '0;
      res_out   <= '0;
      res_flag  <= '0;
      res_op    <= '0;
`ifdef SEQ_DIVZ_HALT_EN
      err       <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      alu_load <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q <= len_eff;
            pc    <= '0;
            done  <= (len_eff == 5'd0);
`ifdef SEQ_DIVZ_HALT_EN
            err   <= 1'b0;
`endif
          end
        end
        S_FETCH: begin
          alu_op   <= mem[pc];
          res_op   <= mem[pc];
          pair_cnt <= '0;
        end
        S_COLLECT: begin
          if (in_fire) begin
            alu_a    <= in_a;
            alu_b    <= in_b;
            alu_attr <= pair_cnt;
            alu_load <= 1'b1;
            pair_cnt <= pair_cnt + 3'd1;
            // Latency is counted from the acceptance edge, so this edge is cycle 1.
            lat_cnt  <= 3'd1;
          end
        end
        S_EXEC: begin
          if (lat_hit) begin
            res_out   <= alu_out;
            res_flag  <= alu_flag;
            res_valid <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        S_OUTPUT: begin
          if (res_fire) begin
            res_valid <= 1'b0;
            if (abort_run) begin
              pc <= '0;
`ifdef SEQ_DIVZ_HALT_EN
              err <= 1'b1;
`endif
            end else if (last_instr) begin
              done <= 1'b1;
              pc   <= '0;
            end else begin
              pc <= pc + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus randomized programs
// checked against a program-level reference model. Honours SEQ_DIVZ_HALT_EN when defined.
module tb_alu_op_sequencer;

  localparam int ALU_LAT = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [3:0] prog_data = '0;
  logic [4:0] prog_len = '0;
  logic       start = 1'b0;
  logic       busy, done;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0, in_b = '0;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic       alu_load;
  logic [2:0] alu_attr;
  logic [7:0] alu_out;
  logic [8:0] alu_flag;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_out;
  logic [8:0] res_flag;
  logic [3:0] res_op;
  logic [2:0] state_dbg;
`ifdef SEQ_DIVZ_HALT_EN
  logic       err;
`endif

  int vectors = 0;
  int miscompares = 0;

  alu_op_sequencer #(.PROG_DEPTH(16), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start), .busy(busy),
    .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_load(alu_load),
    .alu_attr(alu_attr), .alu_out(alu_out), .alu_flag(alu_flag),
    .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out),
    .res_flag(res_flag), .res_op(res_op),
`ifdef SEQ_DIVZ_HALT_EN
    .err(err),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ---------------- ALU stand-in ----------------
  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd3:    return (b == 8'd0) ? 8'hFF : a / b;
      4'd5:    return a | b;
      default: return a ^ b ^ {4'h0, op};
    endcase
  endfunction

  function automatic logic [8:0] flag_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    return {a, (op == 4'd3 && b == 8'd0)};
  endfunction

  assign alu_out  = alu_fn(alu_op, alu_a, alu_b);
  assign alu_flag = flag_fn(alu_op, alu_a, alu_b);

  // ---------------- observation (scoreboard inputs) ----------------
  int         cyc_ctr = 0;
  int         load_cnt, done_cnt, rise_cyc;
  logic       res_prev = 1'b0;
  int         load_cyc_q[$];
  logic [2:0] got_attr_q[$];
  logic [7:0] got_q[$];
  logic [8:0] got_flag_q[$];
  logic [3:0] got_op_q[$];

  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  always @(negedge clk) begin
    if (alu_load) begin
      load_cnt++;
      got_attr_q.push_back(alu_attr);
      load_cyc_q.push_back(cyc_ctr);
    end
    if (done) done_cnt++;
    if (res_valid && !res_prev) rise_cyc = cyc_ctr;
    res_prev = res_valid;
    if (res_valid && res_ready) begin
      got_q.push_back(res_out);
      got_flag_q.push_back(res_flag);
      got_op_q.push_back(res_op);
    end
  end

  // ---------------- reference model ----------------
  logic [3:0] model_mem [16];
  logic [7:0] pa_q[$], pb_q[$];
  logic [7:0] exp_q[$];
  logic [8:0] exp_flag_q[$];
  logic [3:0] exp_op_q[$];
  logic [2:0] exp_attr_q[$];
  int         exp_done;
  bit         exp_err;

  // Walks the program the way the spec describes it: each instruction consumes its
  // pair count, the ALU result reflects the final pair, the run stops at the length.
  task automatic build_model(input int len, input bit gen_pairs);
    int eff, pi, n;
    logic [3:0] op;
    logic [7:0] la, lb;
    eff = (len > 16) ? 16 : len;
    exp_q.delete(); exp_flag_q.delete(); exp_op_q.delete(); exp_attr_q.delete();
    if (gen_pairs) begin pa_q.delete(); pb_q.delete(); end
    pi = 0; exp_err = 1'b0; la = '0; lb = '0;
    for (int i = 0; i < eff; i++) begin
      op = model_mem[i];
      n = (op <= 4'd12) ? 1 : (op <= 4'd14) ? 2 : 5;
      for (int k = 0; k < n; k++) begin
        if (gen_pairs) begin
          pa_q.push_back(8'($urandom_range(0, 255)));
          if (op == 4'd3 && $urandom_range(0, 3) == 0) pb_q.push_back(8'd0);
          else pb_q.push_back(8'($urandom_range(0, 255)));
        end
        exp_attr_q.push_back(3'(k));
        la = pa_q[pi]; lb = pb_q[pi];
        pi++;
      end
      exp_q.push_back(alu_fn(op, la, lb));
      exp_flag_q.push_back(flag_fn(op, la, lb));
      exp_op_q.push_back(op);
`ifdef SEQ_DIVZ_HALT_EN
      if (op == 4'd3 && lb == 8'd0) begin exp_err = 1'b1; break; end
`endif
    end
    exp_done = exp_err ? 0 : 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    load_cnt = 0; done_cnt = 0; rise_cyc = -1;
    load_cyc_q.delete(); got_attr_q.delete();
    got_q.delete(); got_flag_q.delete(); got_op_q.delete();
  endtask

  task automatic write_mem(input logic [3:0] addr, input logic [3:0] data);
    prog_we = 1'b1; prog_addr = addr; prog_data = data;
    model_mem[addr] = data;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic start_prog(input int len);
    prog_len = 5'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_pair(input logic [7:0] a, input logic [7:0] b);
    int n;
    in_valid = 1'b1; in_a = a; in_b = b; n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    vectors++;
    if (!in_ready) begin
      miscompares++;
      $display("FAIL pair_accept_timeout in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Runs a program feeding pa_q/pb_q with random input gaps and result stalls.
  task automatic run_prog(input int len, input int gap, input int stall, input bit co_write);
    int  cyc, pidx;
    bit  fire;
    clear_obs();
    pidx = 0;
    prog_len = 5'(len); start = 1'b1;
    if (co_write) begin
      prog_we = 1'b1; prog_addr = 4'd0; prog_data = model_mem[0];
    end
    @(posedge clk); #1;
    start = 1'b0; prog_we = 1'b0;
    cyc = 0;
    while (busy && cyc < 3000) begin
      if (pidx < pa_q.size() && $urandom_range(0, 99) >= gap) begin
        in_valid = 1'b1; in_a = pa_q[pidx]; in_b = pb_q[pidx];
      end else begin
        in_valid = 1'b0;
      end
      res_ready = ($urandom_range(0, 99) >= stall);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      if (fire) pidx++;
      cyc++;
    end
    in_valid = 1'b0; res_ready = 1'b0;
    vectors++;
    if (busy) begin
      miscompares++;
      $display("FAIL run_timeout busy=%0b required 0", busy);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, in_ready, alu_load, res_valid} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b required=00000", {busy, done, in_ready, alu_load, res_valid});
    end
    vectors++;
    if ({alu_op, alu_a, alu_b, alu_attr} !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_alu got=%h required=0", {alu_op, alu_a, alu_b, alu_attr});
    end
    vectors++;
    if ({res_out, res_flag, res_op} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_res got=%h required=0", {res_out, res_flag, res_op});
    end
`ifdef SEQ_DIVZ_HALT_EN
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b required=0", err); end
`endif
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    write_mem(4'd0, 4'd0);
    pa_q = '{8'h05}; pb_q = '{8'h03};
    run_prog(1, 0, 0, 1'b0);
    vectors++;
    if (load_cnt != 1) begin miscompares++; $display("FAIL single_loads got=%0d required=1", load_cnt); end
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== 8'h08 || got_op_q[0] !== 4'd0 || got_flag_q[0] !== 9'h00A) begin
      miscompares++;
      $display("FAIL single_result n=%0d out=%h op=%h flag=%h required n=1 out=08 op=0 flag=00a",
               got_q.size(), got_q[0], got_op_q[0], got_flag_q[0]);
    end
    vectors++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done done_cnt=%0d busy=%b required 1/0", done_cnt, busy);
    end
    vectors++;
    if (load_cyc_q.size() != 1 || rise_cyc - load_cyc_q[0] != ALU_LAT) begin
      miscompares++;
      $display("FAIL single_latency got=%0d required=%0d", rise_cyc - load_cyc_q[0], ALU_LAT);
    end
  endtask

  task automatic test_program3();
    write_mem(4'd0, 4'd0); write_mem(4'd1, 4'd1); write_mem(4'd2, 4'd5);
    pa_q = '{8'h10, 8'h10, 8'h0F}; pb_q = '{8'h01, 8'h01, 8'hF0};
    run_prog(3, 30, 40, 1'b0);
    vectors++;
    if (got_q.size() != 3 || got_q[0] !== 8'h11 || got_q[1] !== 8'h0F || got_q[2] !== 8'hFF) begin
      miscompares++;
      $display("FAIL prog3_results n=%0d got=%h %h %h required 11 0f ff",
               got_q.size(), got_q[0], got_q[1], got_q[2]);
    end
    vectors++;
    if (got_op_q.size() != 3 || got_op_q[0] !== 4'd0 || got_op_q[1] !== 4'd1 || got_op_q[2] !== 4'd5) begin
      miscompares++;
      $display("FAIL prog3_ops got=%h %h %h required 0 1 5", got_op_q[0], got_op_q[1], got_op_q[2]);
    end
    vectors++;
    if (done_cnt != 1) begin miscompares++; $display("FAIL prog3_done got=%0d required=1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] la, lb;
    int n;
    bit attr_ok;
    write_mem(4'd0, 4'd15);
    clear_obs();
    res_ready = 1'b1;
    start_prog(1);
    n = 0;
    while (!in_ready && n < 10) begin @(posedge clk); #1; n++; end
    la = '0; lb = '0;
    for (int k = 0; k < 5; k++) begin
      la = 8'($urandom_range(0, 255)); lb = 8'($urandom_range(0, 255));
      in_valid = 1'b1; in_a = la; in_b = lb;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready_%0d got=%b required=1", k, in_ready);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_after got=%b required=0", in_ready); end
    in_valid = 1'b0;
    n = 0;
    while (busy && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    res_ready = 1'b0;
    attr_ok = (got_attr_q.size() == 5);
    for (int k = 0; k < got_attr_q.size(); k++) if (got_attr_q[k] !== 3'(k)) attr_ok = 1'b0;
    vectors++;
    if (load_cnt != 5 || !attr_ok) begin
      miscompares++;
      $display("FAIL b2b_loads count=%0d attr_seq_ok=%0b required 5/1", load_cnt, attr_ok);
    end
    vectors++;
    if (load_cyc_q.size() != 5 || load_cyc_q[4] - load_cyc_q[0] != 4) begin
      miscompares++;
      $display("FAIL b2b_consecutive span=%0d required=4", load_cyc_q[4] - load_cyc_q[0]);
    end
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== alu_fn(4'd15, la, lb) || done_cnt != 1) begin
      miscompares++;
      $display("FAIL b2b_result n=%0d out=%h done=%0d required n=1 out=%h done=1",
               got_q.size(), got_q[0], done_cnt, alu_fn(4'd15, la, lb));
    end
  endtask

  task automatic test_hold();
    int n;
    write_mem(4'd0, 4'd2);
    clear_obs();
    res_ready = 1'b0;
    start_prog(1);
    drive_pair(8'h12, 8'h34);
    n = 0;
    while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int k = 0; k < 10; k++) begin
      start = k[0]; prog_we = 1'b1; prog_addr = 4'd0; prog_data = 4'd9;
      vectors++;
      if ({res_valid, busy, res_out, res_flag, res_op} !== {1'b1, 1'b1, 8'h24, 9'h024, 4'd2}) begin
        miscompares++;
        $display("FAIL hold_%0d valid=%b busy=%b out=%h flag=%h op=%h required 1 1 24 024 2",
                 k, res_valid, busy, res_out, res_flag, res_op);
      end
      @(posedge clk); #1;
    end
    start = 1'b0; prog_we = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    vectors++;
    if ({done, busy, res_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL hold_release done/busy/valid=%b required=100", {done, busy, res_valid});
    end
    // Memory must still hold opcode 2 despite the writes attempted while busy.
    pa_q = '{8'h01}; pb_q = '{8'h01};
    run_prog(1, 0, 0, 1'b0);
    vectors++;
    if (got_op_q.size() != 1 || got_op_q[0] !== 4'd2 || got_q[0] !== 8'h02) begin
      miscompares++;
      $display("FAIL hold_mem_intact op=%h out=%h required op=2 out=02", got_op_q[0], got_q[0]);
    end
  endtask

  task automatic test_reset_mid();
    write_mem(4'd0, 4'd14); write_mem(4'd1, 4'd0);
    clear_obs();
    start_prog(2);
    drive_pair(8'h55, 8'h66);
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({busy, in_ready, res_valid, alu_op} !== 7'd0) begin
      miscompares++;
      $display("FAIL midreset_state busy=%b in_ready=%b valid=%b op=%h required 0 0 0 0",
               busy, in_ready, res_valid, alu_op);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (done_cnt != 0) begin miscompares++; $display("FAIL midreset_done got=%0d required=0", done_cnt); end
    pa_q = '{8'h11, 8'h22, 8'h33}; pb_q = '{8'h01, 8'h02, 8'h03};
    run_prog(2, 20, 20, 1'b0);
    vectors++;
    if (got_q.size() != 2 || got_q[0] !== 8'h2E || got_q[1] !== 8'h36 ||
        got_op_q[0] !== 4'd14 || got_op_q[1] !== 4'd0) begin
      miscompares++;
      $display("FAIL midreset_rerun n=%0d out=%h %h op=%h %h required 2e 36 / e 0",
               got_q.size(), got_q[0], got_q[1], got_op_q[0], got_op_q[1]);
    end
    vectors++;
    if (done_cnt != 1 || load_cnt != 3) begin
      miscompares++;
      $display("FAIL midreset_counts done=%0d loads=%0d required 1/3", done_cnt, load_cnt);
    end
  endtask

  task automatic test_len_zero();
    clear_obs();
    start_prog(0);
    vectors++;
    if ({done, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL len0_pulse done/busy=%b required=10", {done, busy});
    end
    @(posedge clk); #1;
    vectors++;
    if ({done, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL len0_after done/busy=%b required=00", {done, busy});
    end
  endtask

  task automatic test_divz();
    write_mem(4'd0, 4'd3); write_mem(4'd1, 4'd0);
    pa_q = '{8'h08, 8'h01}; pb_q = '{8'h00, 8'h02};
    run_prog(2, 0, 0, 1'b0);
    vectors++;
    if (got_q.size() < 1 || got_q[0] !== 8'hFF || got_flag_q[0][0] !== 1'b1 || got_op_q[0] !== 4'd3) begin
      miscompares++;
      $display("FAIL divz_first n=%0d out=%h flag0=%b op=%h required ff 1 3",
               got_q.size(), got_q[0], got_flag_q[0][0], got_op_q[0]);
    end
`ifdef SEQ_DIVZ_HALT_EN
    vectors++;
    if (got_q.size() != 1 || done_cnt != 0 || err !== 1'b1 || alu_op !== 4'd3) begin
      miscompares++;
      $display("FAIL divz_halt n=%0d done=%0d err=%b alu_op=%h required 1 0 1 3",
               got_q.size(), done_cnt, err, alu_op);
    end
    start_prog(0);
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL divz_err_clear got=%b required=0", err); end
`else
    vectors++;
    if (got_q.size() != 2 || got_q[1] !== 8'h03 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL divz_continue n=%0d out1=%h done=%0d required 2 03 1",
               got_q.size(), got_q[1], done_cnt);
    end
`endif
  endtask

  task automatic test_random();
    int len;
    bit ok;
    for (int it = 0; it < 25; it++) begin
      for (int a = 1; a < 16; a++) write_mem(4'(a), 4'($urandom_range(0, 15)));
      model_mem[0] = 4'($urandom_range(0, 15));
      len = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 16)) : int'($urandom_range(17, 31));
      build_model(len, 1'b1);
      run_prog(len, int'($urandom_range(0, 50)), int'($urandom_range(0, 50)), 1'b1);
      vectors++;
      if (got_q.size() != exp_q.size()) begin
        miscompares++;
        $display("FAIL rand%0d_count got=%0d required=%0d", it, got_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
        vectors++;
        if (got_q[k] !== exp_q[k] || got_flag_q[k] !== exp_flag_q[k] || got_op_q[k] !== exp_op_q[k]) begin
          miscompares++;
          $display("FAIL rand%0d_res%0d got out=%h flag=%h op=%h required out=%h flag=%h op=%h",
                   it, k, got_q[k], got_flag_q[k], got_op_q[k], exp_q[k], exp_flag_q[k], exp_op_q[k]);
        end
      end
      ok = (got_attr_q.size() == exp_attr_q.size());
      for (int k = 0; k < exp_attr_q.size() && k < got_attr_q.size(); k++)
        if (got_attr_q[k] !== exp_attr_q[k]) ok = 1'b0;
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL rand%0d_attr loads=%0d required=%0d (sequence differs)",
                 it, got_attr_q.size(), exp_attr_q.size());
      end
      vectors++;
      if (done_cnt != exp_done) begin
        miscompares++;
        $display("FAIL rand%0d_done got=%0d required=%0d", it, done_cnt, exp_done);
      end
`ifdef SEQ_DIVZ_HALT_EN
      vectors++;
      if (err !== exp_err) begin
        miscompares++;
        $display("FAIL rand%0d_err got=%b required=%b", it, err, exp_err);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_program3();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_len_zero();
    test_divz();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
